execute_stage: RTL and testbench

//  Consumer of the ID/EX pipeline register: performs the EX stage of the 5-stage MIPS core and latches results into the EX/MEM register.

---
 rtl/execute_stage.sv | 116 +++++++++++
 tb/tb_execute_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS core: ALU control decode, operand/destination
// selection, branch target, and the EX/MEM pipeline register.
module execute_stage #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic [DW-1:0] id_pc_plus4,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_rt,
   input  logic [4:0]    id_rd,
   input  logic          id_reg_dst,
   input  logic          id_branch,
   input  logic          id_mem_read,
   input  logic          id_mem_to_reg,
   input  logic [2:0]    id_alu_op,
   input  logic          id_mem_write,
   input  logic          id_alu_src,
   input  logic          id_reg_write,
   output logic [DW-1:0] ex_branch_target,
   output logic          ex_zero,
   output logic [DW-1:0] ex_alu_result,
   output logic [DW-1:0] ex_store_data,
   output logic [4:0]    ex_write_reg,
   output logic          ex_branch,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg,
   output logic          ex_reg_write
);

   typedef enum logic [2:0] {
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_LUI
   } aluFn_t;

   aluFn_t        aluFn;
   logic [DW-1:0] opB;
   logic [DW-1:0] aluResult;
   logic [DW-1:0] branchTarget;
   logic [4:0]    writeReg;

   assign opB          = id_alu_src ? id_imm : id_rd2;
   assign writeReg     = id_reg_dst ? id_rd : id_rt;
   assign branchTarget = id_pc_plus4 + {id_imm[DW-3:0], 2'b00};

   // Unlisted op/funct codes fall back to add so nothing undefined reaches the register
   always_comb begin
      aluFn = FN_ADD;
      case (id_alu_op)
         3'b001: aluFn = FN_SUB;
         3'b010: begin
            case (id_imm[5:0])
               6'b100010: aluFn = FN_SUB;
               6'b100100: aluFn = FN_AND;
               6'b100101: aluFn = FN_OR;
               6'b100110: aluFn = FN_XOR;
               6'b100111: aluFn = FN_NOR;
               6'b101010: aluFn = FN_SLT;
               default:   aluFn = FN_ADD;
            endcase
         end
         3'b011:  aluFn = FN_AND;
         3'b100:  aluFn = FN_OR;
         3'b101:  aluFn = FN_SLT;
         3'b110:  aluFn = FN_LUI;
         default: aluFn = FN_ADD;
      endcase
   end

   always_comb begin
      aluResult = '0;
      case (aluFn)
         FN_ADD: aluResult = id_rd1 + opB;
         FN_SUB: aluResult = id_rd1 - opB;
         FN_AND: aluResult = id_rd1 & opB;
         FN_OR:  aluResult = id_rd1 | opB;
         FN_XOR: aluResult = id_rd1 ^ opB;
         FN_NOR: aluResult = ~(id_rd1 | opB);
         FN_SLT: aluResult = {{(DW-1){1'b0}}, ($signed(id_rd1) < $signed(opB))};
         FN_LUI: aluResult = opB << 16;
         default: aluResult = '0;
      endcase
   end

   // Flush takes priority over stall: a bubble is inserted even while MEM holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_branch_target <= '0;
         ex_zero          <= 1'b0;
         ex_alu_result    <= '0;
         ex_store_data    <= '0;
         ex_write_reg     <= '0;
         ex_branch        <= 1'b0;
         ex_mem_read      <= 1'b0;
         ex_mem_write     <= 1'b0;
         ex_mem_to_reg    <= 1'b0;
         ex_reg_write     <= 1'b0;
      end else if (flush || !stall) begin
         ex_branch_target <= branchTarget;
         ex_zero          <= (aluResult == '0);
         ex_alu_result    <= aluResult;
         ex_store_data    <= id_rd2;
         ex_write_reg     <= flush ? 5'd0 : writeReg;
         ex_branch        <= id_branch     & ~flush;
         ex_mem_read      <= id_mem_read   & ~flush;
         ex_mem_write     <= id_mem_write  & ~flush;
         ex_mem_to_reg    <= id_mem_to_reg & ~flush;
         ex_reg_write     <= id_reg_write  & ~flush;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized
// traffic compared every cycle against a behavioural EX/MEM model.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [31:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rt, id_rd;
   logic        id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
   logic [2:0]  id_alu_op;
   logic        id_mem_write, id_alu_src, id_reg_write;
   logic [31:0] ex_branch_target, ex_alu_result, ex_store_data;
   logic        ex_zero;
   logic [4:0]  ex_write_reg;
   logic        ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;

   typedef struct packed {
      logic [31:0] tgt;
      logic        zero;
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  wr;
      logic        br, mr, mw, m2r, rw;
   } exState_t;

   exState_t expS;
   logic     checkEn = 1'b0;
   int       nChk = 0;
   int       nPass = 0;

   always #5 clk = ~clk;

   execute_stage #(.DW(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rt(id_rt), .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
      .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .ex_branch_target(ex_branch_target), .ex_zero(ex_zero), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_write(ex_reg_write)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      nChk++;
      if (act === req) nPass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
   endtask

   function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd1: return a - b;
         3'd2: case (fn)
                  6'h22:   return a - b;
                  6'h24:   return a & b;
                  6'h25:   return a | b;
                  6'h26:   return a ^ b;
                  6'h27:   return ~(a | b);
                  6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
                  default: return a + b;
               endcase
         3'd3: return a & b;
         3'd4: return a | b;
         3'd5: return (sa < sb) ? 32'd1 : 32'd0;
         3'd6: return b * 32'd65536;
         default: return a + b;
      endcase
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         cmp("branch_target", ex_branch_target, expS.tgt);
         cmp("zero",          {31'b0, ex_zero},       {31'b0, expS.zero});
         cmp("alu_result",    ex_alu_result,          expS.res);
         cmp("store_data",    ex_store_data,          expS.sd);
         cmp("write_reg",     {27'b0, ex_write_reg},  {27'b0, expS.wr});
         cmp("branch",        {31'b0, ex_branch},     {31'b0, expS.br});
         cmp("mem_read",      {31'b0, ex_mem_read},   {31'b0, expS.mr});
         cmp("mem_write",     {31'b0, ex_mem_write},  {31'b0, expS.mw});
         cmp("mem_to_reg",    {31'b0, ex_mem_to_reg}, {31'b0, expS.m2r});
         cmp("reg_write",     {31'b0, ex_reg_write},  {31'b0, expS.rw});
      end
   end

   // Called at posedge+1; applies current inputs across one edge and advances the model
   task automatic step();
      exState_t    nxt;
      logic [31:0] b;
      nxt = expS;
      b   = id_alu_src ? id_imm : id_rd2;
      if (flush || !stall) begin
         nxt.res  = refAlu(id_alu_op, id_imm[5:0], id_rd1, b);
         nxt.zero = (nxt.res == 32'd0);
         nxt.tgt  = id_pc_plus4 + id_imm * 32'd4;
         nxt.sd   = id_rd2;
         nxt.wr   = flush ? 5'd0 : (id_reg_dst ? id_rd : id_rt);
         nxt.br   = flush ? 1'b0 : id_branch;
         nxt.mr   = flush ? 1'b0 : id_mem_read;
         nxt.mw   = flush ? 1'b0 : id_mem_write;
         nxt.m2r  = flush ? 1'b0 : id_mem_to_reg;
         nxt.rw   = flush ? 1'b0 : id_reg_write;
      end
      @(posedge clk);
      #1;
      expS = nxt;
   endtask

   task automatic idle();
      stall = 0; flush = 0;
      id_pc_plus4 = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
      id_rt = 0; id_rd = 0; id_reg_dst = 0; id_branch = 0; id_mem_read = 0;
      id_mem_to_reg = 0; id_alu_op = 0; id_mem_write = 0; id_alu_src = 0; id_reg_write = 0;
   endtask

   task automatic randomInputs();
      logic [5:0] functs [7];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
      id_pc_plus4   = $urandom;
      id_rd1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      id_rd2        = ($urandom_range(0, 3) == 0) ? id_rd1 : $urandom;
      id_imm        = $urandom;
      if ($urandom_range(0, 3) != 0) id_imm[5:0] = functs[$urandom_range(0, 6)];
      id_rt         = 5'($urandom);
      id_rd         = 5'($urandom);
      id_reg_dst    = 1'($urandom);
      id_branch     = 1'($urandom);
      id_mem_read   = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_alu_op     = 3'($urandom);
      id_mem_write  = 1'($urandom);
      id_alu_src    = 1'($urandom);
      id_reg_write  = 1'($urandom);
      stall         = ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 8) == 0);
   endtask

   initial begin
      idle();
      rst  = 1'b1;
      expS = '0;
      @(posedge clk);
      #1;
      cmp("reset_alu_result", ex_alu_result, 32'd0);
      cmp("reset_reg_write",  {31'b0, ex_reg_write}, 32'd0);
      rst = 1'b0;
      checkEn = 1'b1;

      // beq with equal operands
      idle();
      id_rd1 = 32'h1234; id_rd2 = 32'h1234; id_alu_op = 3'b001;
      id_pc_plus4 = 32'h100; id_imm = 32'hFFFF_FFFE; id_branch = 1;
      step();
      cmp("beq_zero",   {31'b0, ex_zero}, 32'd1);
      cmp("beq_target", ex_branch_target, 32'h0000_00F8);
      cmp("beq_branch", {31'b0, ex_branch}, 32'd1);

      // signed slt both ways, then sub wrap
      idle();
      id_alu_op = 3'b010; id_imm = 32'h2A; id_rd1 = 32'hFFFF_FFFF; id_rd2 = 32'd1; id_reg_dst = 1; id_rd = 5'd3; id_reg_write = 1;
      step();
      cmp("slt_neg_lt_pos", ex_alu_result, 32'd1);
      id_rd1 = 32'd1; id_rd2 = 32'hFFFF_FFFF;
      step();
      cmp("slt_pos_lt_neg", ex_alu_result, 32'd0);
      id_alu_op = 3'b001; id_imm = 32'd0; id_rd1 = 32'd0; id_rd2 = 32'd1;
      step();
      cmp("sub_wrap", ex_alu_result, 32'hFFFF_FFFF);

      // lw address calculation
      idle();
      id_alu_src = 1; id_rd1 = 32'h1000; id_imm = 32'hFFFF_FFFC; id_rt = 5'd9;
      id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
      step();
      cmp("lw_addr",     ex_alu_result, 32'h0000_0FFC);
      cmp("lw_wreg",     {27'b0, ex_write_reg}, 32'd9);
      cmp("lw_mem_read", {31'b0, ex_mem_read}, 32'd1);

      // three stalled cycles with changing inputs
      for (int i = 0; i < 3; i++) begin
         randomInputs();
         stall = 1; flush = 0;
         step();
      end
      cmp("stall_hold_result", ex_alu_result, 32'h0000_0FFC);
      cmp("stall_hold_wreg",   {27'b0, ex_write_reg}, 32'd9);
      cmp("stall_hold_mr",     {31'b0, ex_mem_read}, 32'd1);

      // stall and flush together: bubble wins
      randomInputs();
      stall = 1; flush = 1; id_reg_write = 1; id_mem_write = 1; id_reg_dst = 1; id_rd = 5'd17;
      step();
      cmp("sf_reg_write", {31'b0, ex_reg_write}, 32'd0);
      cmp("sf_mem_write", {31'b0, ex_mem_write}, 32'd0);
      cmp("sf_write_reg", {27'b0, ex_write_reg}, 32'd0);

      // asynchronous reset mid-stream
      idle();
      id_rd1 = 32'hDEAD_0000; id_rd2 = 32'h55; id_rd = 5'd12; id_reg_dst = 1; id_reg_write = 1; id_mem_write = 1;
      step();
      #2;
      rst  = 1'b1;
      expS = '0;
      #1;
      cmp("async_rst_result", ex_alu_result, 32'd0);
      cmp("async_rst_sd",     ex_store_data, 32'd0);
      cmp("async_rst_wreg",   {27'b0, ex_write_reg}, 32'd0);
      cmp("async_rst_rw",     {31'b0, ex_reg_write}, 32'd0);
      @(posedge clk);
      #1;
      cmp("rst_held_mw", {31'b0, ex_mem_write}, 32'd0);
      rst = 1'b0;

      // add 5+7 via R-type after release
      idle();
      id_alu_op = 3'b010; id_imm = 32'h20; id_rd1 = 32'd5; id_rd2 = 32'd7; id_reg_write = 1;
      step();
      cmp("add_after_rst", ex_alu_result, 32'd12);
      cmp("add_reg_write", {31'b0, ex_reg_write}, 32'd1);

      // lui pin
      idle();
      id_alu_op = 3'b110; id_alu_src = 1; id_imm = 32'h0000_ABCD;
      step();
      cmp("lui", ex_alu_result, 32'hABCD_0000);

      for (int i = 0; i < 400; i++) begin
         randomInputs();
         step();
      end

      @(negedge clk);
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
